// File: rtl/ddr2_tg_pkg.sv
// ddr2_tg_pkg: shared FSM/mode encodings and pattern constants for axi_traffic_gen
package ddr2_tg_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_INIT, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
  } tg_state_e;
  typedef enum logic [1:0] {
    MODE_WR = 2'd0, MODE_RD = 2'd1, MODE_WR_RD = 2'd2, MODE_RSVD = 2'd3
  } tg_mode_e;
  localparam int ERR_CNT_W = 16;
  localparam logic [63:0] LFSR_SEED = '1;
  // Right-shifting Galois tap masks giving maximal-length sequences
  function automatic logic [63:0] lfsr_taps(input int w);
    return w == 8  ? 64'h0000_0000_0000_00B8 :
           w == 16 ? 64'h0000_0000_0000_B400 :
           w == 32 ? 64'h0000_0000_A300_0000 :
           w == 64 ? 64'hD800_0000_0000_0000 : 64'h1 << (w - 1);
  endfunction
endpackage

// File: rtl/tg_pattern_gen.sv
// tg_pattern_gen: data pattern source (counter, or LFSR when TRAFFIC_GEN_LFSR_EN is defined)
module tg_pattern_gen
  import ddr2_tg_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d, nxt;
`ifdef TRAFFIC_GEN_LFSR_EN
  localparam logic [W-1:0] INIT = W'(LFSR_SEED);
  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
  assign nxt = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
`else
  localparam logic [W-1:0] INIT = W'(1);
  assign nxt = value_q + W'(1);
`endif
  always_comb value_d = clear ? INIT : step ? nxt : value_q;
  always_ff @(posedge clk) value_q <= rst ? INIT : value_d;
  assign value = value_q;
endmodule

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: AXI burst write/read traffic generator with read-back checker.
// Define TRAFFIC_GEN_LFSR_EN for an LFSR data pattern instead of the counter.
module axi_traffic_gen
  import ddr2_tg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 27,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    BURST_LEN  = 8,
  parameter int                    NUM_BURSTS = 16,
  parameter int                    ADDR_STEP  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic                  rlast,
  input  logic [DATA_WIDTH-1:0] rdata
);
  localparam int BW = $clog2(NUM_BURSTS) + 1;
  tg_state_e state_q, state_d;
  logic rd_only_q, rd_only_d, wr_only_q, wr_only_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [8:0] beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, first_err_addr_q, first_err_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic w_clr, w_step, r_clr, r_step, last_beat, last_burst;
  logic [DATA_WIDTH-1:0] w_val, r_val;
  logic [1:0] beat_errs;
  logic [ERR_CNT_W:0] err_sum;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  tg_pattern_gen #(.W(DATA_WIDTH)) u_wr_pat (
    .clk(clk), .rst(rst), .clear(w_clr), .step(w_step), .value(w_val)
  );
  tg_pattern_gen #(.W(DATA_WIDTH)) u_rd_pat (
    .clk(clk), .rst(rst), .clear(r_clr), .step(r_step), .value(r_val)
  );
  assign last_beat  = beat_q == 9'(BURST_LEN - 1);
  assign last_burst = burst_q == BW'(NUM_BURSTS - 1);
  assign addr_nxt   = last_burst ? BASE_ADDR : addr_q + ADDR_WIDTH'(ADDR_STEP);
  // Data and rlast mismatches on the same beat each count as one error
  assign beat_errs  = {1'b0, rdata != r_val} + {1'b0, rlast != last_beat};
  assign err_sum    = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(beat_errs);
  assign busy           = state_q != ST_IDLE && state_q != ST_DONE;
  assign done           = state_q == ST_DONE;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign awvalid        = state_q == ST_AW;
  assign awaddr         = addr_q;
  assign awlen          = 8'(BURST_LEN - 1);
  assign wvalid         = state_q == ST_W;
  assign wlast          = state_q == ST_W && last_beat;
  assign wdata          = w_val;
  assign bready         = state_q == ST_B;
  assign arvalid        = state_q == ST_AR;
  assign araddr         = addr_q;
  assign arlen          = 8'(BURST_LEN - 1);
  assign rready         = state_q == ST_R;
  always_comb begin
    state_d          = state_q;
    rd_only_d        = rd_only_q;
    wr_only_d        = wr_only_q;
    burst_d          = burst_q;
    beat_d           = beat_q;
    addr_d           = addr_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    w_clr            = 1'b0;
    w_step           = 1'b0;
    r_clr            = 1'b0;
    r_step           = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        rd_only_d        = mode == MODE_RD;
        wr_only_d        = mode == MODE_WR;
        burst_d          = '0;
        beat_d           = '0;
        addr_d           = BASE_ADDR;
        err_cnt_d        = '0;
        first_err_addr_d = '0;
        w_clr            = 1'b1;
        r_clr            = 1'b1;
        state_d          = !init_end ? ST_WAIT_INIT : mode == MODE_RD ? ST_AR : ST_AW;
      end
      ST_WAIT_INIT: if (init_end) state_d = rd_only_q ? ST_AR : ST_AW;
      ST_AW: if (awready) state_d = ST_W;
      ST_W: if (wready) begin
        w_step  = 1'b1;
        beat_d  = last_beat ? '0 : beat_q + 9'd1;
        state_d = last_beat ? ST_B : ST_W;
      end
      ST_B: if (bvalid) begin
        burst_d = last_burst ? '0 : burst_q + BW'(1);
        addr_d  = addr_nxt;
        r_clr   = last_burst;
        state_d = !last_burst ? ST_AW : wr_only_q ? ST_DONE : ST_AR;
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: if (rvalid) begin
        r_step    = 1'b1;
        err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
        if (beat_errs != 2'd0 && err_cnt_q == '0) first_err_addr_d = addr_q;
        beat_d = last_beat ? '0 : beat_q + 9'd1;
        if (last_beat) begin
          burst_d = last_burst ? '0 : burst_q + BW'(1);
          addr_d  = addr_nxt;
          state_d = last_burst ? ST_DONE : ST_AR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      rd_only_q        <= 1'b0;
      wr_only_q        <= 1'b0;
      burst_q          <= '0;
      beat_q           <= '0;
      addr_q           <= BASE_ADDR;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      rd_only_q        <= rd_only_d;
      wr_only_q        <= wr_only_d;
      burst_q          <= burst_d;
      beat_q           <= beat_d;
      addr_q           <= addr_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: directed bench with a behavioural AXI slave memory
module tb_axi_traffic_gen;
  logic clk = 1'b0, rst = 1'b1, init_end = 1'b1, start = 1'b0, start_2 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic awvalid, wvalid, wlast, bready, arvalid, rready, busy, done;
  logic awready = 1'b1, wready = 1'b1, bvalid = 1'b0, arready = 1'b1;
  logic rvalid = 1'b0, rlast = 1'b0;
  logic [15:0] rdata = '0, wdata, err_cnt;
  logic [26:0] awaddr, araddr, first_err_addr;
  logic [7:0] awlen, arlen;
  logic awvalid_2, wvalid_2, wlast_2, bready_2, arvalid_2, rready_2, busy_2, done_2;
  logic [15:0] wdata_2, err_cnt_2;
  logic [26:0] awaddr_2, araddr_2, first_err_addr_2;
  logic [7:0] awlen_2, arlen_2;

  axi_traffic_gen #(.BURST_LEN(8), .NUM_BURSTS(4)) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .start(start), .mode(mode),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
  );

  axi_traffic_gen #(.BURST_LEN(8), .NUM_BURSTS(2), .BASE_ADDR(27'h7FF_FFF0)) dut_wrap (
    .clk(clk), .rst(rst), .init_end(1'b1), .start(start_2), .mode(2'd0),
    .busy(busy_2), .done(done_2), .err_cnt(err_cnt_2), .first_err_addr(first_err_addr_2),
    .awvalid(awvalid_2), .awready(1'b1), .awaddr(awaddr_2), .awlen(awlen_2),
    .wvalid(wvalid_2), .wready(1'b1), .wlast(wlast_2), .wdata(wdata_2),
    .bvalid(1'b1), .bready(bready_2),
    .arvalid(arvalid_2), .arready(1'b1), .araddr(araddr_2), .arlen(arlen_2),
    .rvalid(1'b0), .rready(rready_2), .rlast(1'b0), .rdata(16'h0)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem [0:255];
  logic [26:0] wa = '0, ra = '0;
  logic [15:0] held = '0;
  int wb = 0, rb = 0, stall_bad = 0, stall_cnt = 0, wlast_bad = 0, done_cnt = 0, done_cnt2 = 0;
  bit b_pend = 0, r_active = 0, toggle_w = 0, corrupt = 0, prev_stall = 0;
  logic [26:0] aw_log[$], aw2_log[$];
  logic [15:0] wd_log[$];

  // Slave: drive inputs at negedge and commit handshakes the next posedge will see
  initial forever begin
    @(negedge clk);
    if (rst) begin
      b_pend = 0; r_active = 0; wb = 0; rb = 0; prev_stall = 0;
    end
    wready = toggle_w ? ~wready : 1'b1;
    bvalid = b_pend;
    rvalid = r_active;
    rlast  = r_active && rb == 7;
    rdata  = r_active ? mem[8'(ra + 27'(rb))] ^ ((corrupt && ra == 27'd32 && rb == 3) ? 16'h0100 : 16'h0) : '0;
    if (prev_stall && wdata !== held) stall_bad++;
    prev_stall = wvalid && !wready;
    held = wdata;
    if (prev_stall) stall_cnt++;
    if (done) done_cnt++;
    if (done_2) done_cnt2++;
    if (awvalid_2) aw2_log.push_back(awaddr_2);
    if (awvalid && awready) begin
      wa = awaddr; wb = 0; aw_log.push_back(awaddr);
    end
    if (wvalid && wready) begin
      mem[8'(wa + 27'(wb))] = wdata;
      wd_log.push_back(wdata);
      if (wlast !== (wb == 7)) wlast_bad++;
      wb++;
      if (wb == 8) b_pend = 1;
    end
    if (bvalid && bready) b_pend = 0;
    if (arvalid && arready) begin
      ra = araddr; rb = 0; r_active = 1;
    end
    if (rvalid && rready) begin
      rb++;
      if (rb == 8) r_active = 0;
    end
  end

  task automatic go(input logic [1:0] m, input bit chk);
    aw_log.delete(); wd_log.delete();
    done_cnt = 0; wlast_bad = 0; stall_bad = 0; stall_cnt = 0;
    mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = (m == 2'd1) ? 2'd0 : 2'd1;
    check("busy_after_start", busy, 1'b1);
    if (chk) check("valid_latency", m == 2'd1 ? arvalid : awvalid, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wbeats"}, wd_log.size(), 32);
    for (int i = 0; i < wd_log.size(); i++) check({tag, "_wdata"}, wd_log[i], 32'(i + 1));
    check({tag, "_awcount"}, aw_log.size(), 4);
    for (int i = 0; i < aw_log.size(); i++) check({tag, "_awaddr"}, aw_log[i], 32'(i * 16));
    check({tag, "_wlast"}, wlast_bad, 0);
  endtask

  initial begin
    int n, hi;
    repeat (3) @(negedge clk);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err_cnt", err_cnt, 16'h0);
    check("rst_first_err", first_err_addr, 27'h0);
    check("rst_awaddr", awaddr, 27'h0);
    check("rst_awlen", awlen, 8'd7);
    check("rst_arlen", arlen, 8'd7);
    check("rst_wrap_awaddr", awaddr_2, 27'h7FF_FFF0);
    rst = 1'b0;
    @(negedge clk);

    go(2'd2, 1);
    wait_done("wr_rd");
    check("wr_rd_err_cnt", err_cnt, 16'h0);
    check("wr_rd_first_err", first_err_addr, 27'h0);
    after_done("wr_rd");
    check_writes("wr_rd");

    go(2'd1, 1);
    wait_done("rd_only");
    check("rd_only_err_cnt", err_cnt, 16'h0);
    after_done("rd_only");
    check("rd_only_no_aw", aw_log.size(), 0);

    corrupt = 1;
    go(2'd2, 1);
    wait_done("corrupt");
    check("corrupt_err_cnt", err_cnt, 16'd1);
    check("corrupt_first_err", first_err_addr, 27'd32);
    after_done("corrupt");
    corrupt = 0;

    init_end = 1'b0;
    toggle_w = 1;
    go(2'd0, 0);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (awvalid) hi++;
    end
    check("init_wait_no_aw", hi, 0);
    check("init_wait_busy", busy, 1'b1);
    init_end = 1'b1;
    @(negedge clk);
    check("init_rise_aw", awvalid, 1'b1);
    wait_done("stall");
    check("stall_err_cnt", err_cnt, 16'h0);
    after_done("stall");
    check_writes("stall");
    check("stall_hold", stall_bad, 0);
    check("stall_seen", stall_cnt > 0, 1'b1);
    toggle_w = 0;

    go(2'd2, 1);
    n = 0;
    while (!(wvalid && wb >= 3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midw_reached", wvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wvalid", wvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_awaddr", awaddr, 27'h0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    go(2'd2, 1);
    wait_done("rerun");
    check("rerun_err_cnt", err_cnt, 16'h0);
    after_done("rerun");
    check_writes("rerun");

    aw2_log.delete();
    done_cnt2 = 0;
    start_2 = 1'b1;
    @(negedge clk);
    start_2 = 1'b0;
    n = 0;
    while (!done_2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wrap_done_seen", done_2, 1'b1);
    check("wrap_awcount", aw2_log.size(), 2);
    if (aw2_log.size() == 2) begin
      check("wrap_awaddr0", aw2_log[0], 27'h7FF_FFF0);
      check("wrap_awaddr1", aw2_log[1], 27'h0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_traffic_gen.md
# axi_traffic_gen

Parametrised AXI traffic generator and self-checker sitting between system stimulus and `ddr2_ctrl`, replacing the fixed-length write-only master. It issues a programmable number of write bursts, read bursts, or a write-then-read-back sequence over a strided address range. It compares every read beat against the regenerated data pattern and reports error count and first failing address.

## Interface
- `ADDR_WIDTH`, 27: AXI address width (row+col+bank bits)
- `DATA_WIDTH`, 16: AXI data width
- `BURST_LEN`, 8: beats per burst, 1..256
- `NUM_BURSTS`, 16: bursts per phase, ≥1
- `ADDR_STEP`, 16: address increment per burst
- `BASE_ADDR`, 0: first burst address
- `clk  in  1`: system clock; all logic rising-edge
- `rst  in  1`: synchronous, active-high reset
- `init_end  in  1`: DDR2 initialisation complete
- `start  in  1`: one-cycle run request, sampled only in IDLE
- `mode  in  2`: 0 write-only, 1 read-only, 2 write-then-read, 3 reserved (treated as 2)
- `busy  out  1`: high from accepted start until DONE
- `done  out  1`: one-cycle pulse at end of run
- `err_cnt  out  16`: read mismatches this run, saturating at 16'hFFFF
- `first_err_addr  out  ADDR_WIDTH`: burst address of first mismatch
- `awvalid/awready/awaddr[ADDR_WIDTH]/awlen[8]`: write address channel; `awlen` = BURST_LEN-1
- `wvalid/wready/wlast/wdata[DATA_WIDTH]`: write data channel
- `bvalid/bready`: write response channel
- `arvalid/arready/araddr[ADDR_WIDTH]/arlen[8]`: read address channel; `arlen` = BURST_LEN-1
- `rvalid/rready/rlast/rdata[DATA_WIDTH]`: read data channel

## Operation
- States: IDLE, WAIT_INIT, AW, W, B, AR, R, DONE.
- IDLE + start: if `init_end`=0 go WAIT_INIT, else go AW (mode 0/2) or AR (mode 1). WAIT_INIT exits on `init_end`=1 the same way.
- AW: `awvalid`=1, `awaddr` = current burst address; on handshake → W.
- W: `wvalid`=1 throughout. `wdata` advances only on `wvalid&wready`. `wlast`=1 on beat BURST_LEN-1. Handshake of the last beat → B.
- B: `bready`=1. On `bvalid`: burst_idx++ and addr += ADDR_STEP. At NUM_BURSTS: mode 0 → DONE; mode 2 → AR with burst_idx, address and pattern reset. Otherwise → AW.
- AR: `arvalid`=1 until handshake → R.
- R: `rready`=1. Each `rvalid` beat compared with the expected pattern. An `rlast` mismatch on a beat (asserted early or missing on beat BURST_LEN-1) also counts one error. On the final beat, continue with the next AR, or go DONE.
- DONE: `done`=1 for one cycle, → IDLE. `err_cnt`/`first_err_addr` hold until the next accepted start, which clears them.
- Pattern (default): 1-based counter, +1 per accepted beat, truncated to DATA_WIDTH. Reset to 1 at start of each phase, so read-back expects exactly what was written.
- Address arithmetic modulo 2^ADDR_WIDTH; wrap is silent.
- Only one transaction outstanding; AW/W never overlap.
- `start` while busy: ignored. `mode` sampled only on accepted start.

## Timing
- Reset values: all valids/readies 0, `wlast` 0, `busy` 0, `done` 0, `err_cnt` 0, `first_err_addr` 0, addresses = BASE_ADDR, `awlen`/`arlen` = BURST_LEN-1 (constant).
- start → `awvalid`/`arvalid` high on the next clock edge (1 cycle latency) when `init_end`=1.
- Valids are registered; once high they stay high with stable payload until handshake.
- Mismatch registered one cycle after the beat. `err_cnt` is final when `done` pulses.
- `rst` mid-run: next edge all channel outputs drop to 0, FSM → IDLE, counters cleared; no `done` pulse.

## Configuration
- `TRAFFIC_GEN_LFSR_EN` defined: pattern is a DATA_WIDTH-bit Galois LFSR (seed all-ones, tap set from the package per width), stepped per accepted beat, reseeded at phase start.
- Not defined: incrementing counter pattern as above. Interface identical either way.

## Structure
- Package `ddr2_tg_pkg`: state encoding, mode encodings, LFSR seed/tap constants, err_cnt width.
- Sub-module `tg_pattern_gen` (clear, step, value), instantiated twice: write-data source and read expected-data source.

## Test plan
- mode 2, BURST_LEN 8, NUM_BURSTS 4, ideal slave memory → 32 writes `wdata` 1..32 at addr 0,16,32,48; reads match; `err_cnt`=0, one `done` pulse.
- Same run, slave corrupts beat 3 of burst 2 → `err_cnt`=1, `first_err_addr`=32.
- `start` with `init_end`=0 for 100 cycles → no `awvalid` until one cycle after `init_end` rises.
- `wready` toggled every other cycle → `wdata` holds while stalled, `wlast` only on 8th handshake, no beat skipped.
- BASE_ADDR = 2^27-16, NUM_BURSTS 2 → second `awaddr` = 0.
- `rst` asserted during W → next edge `wvalid`=0, `busy`=0; new start runs cleanly from BASE_ADDR with `err_cnt`=0.
